// File: rtl/uart_tx_arbiter_if.sv
// Requester handshake and UART MMIO bus shared by uart_tx_arbiter and its neighbours.
// The arbiter is the MMIO bus master; the requesters and the UART register block sit on the slave side.
interface uart_tx_arbiter_if #(
    parameter int N_REQ = 2
);
    logic [N_REQ-1:0]   req_valid;
    logic [8*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]   req_last;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ-1:0]   grant;
    logic               busy;
    logic [1:0]         mmio_addr;
    logic               mmio_wr_en;
    logic [7:0]         mmio_wr_data;
    logic [7:0]         mmio_rd_data;

    modport master (
        input  req_valid, req_data, req_last, mmio_rd_data,
        output req_ready, grant, busy, mmio_addr, mmio_wr_en, mmio_wr_data
    );

    modport slave (
        output req_valid, req_data, req_last, mmio_rd_data,
        input  req_ready, grant, busy, mmio_addr, mmio_wr_en, mmio_wr_data
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte producers,
// with packet locking so a multi-byte message is never interleaved with another.
//
// state | meaning
// IDLE  | status address selected; pick next eligible requester, run lock-idle timer
// POLL  | read UART status until TX-ready (bit1) is set
// WRITE | single cycle: write byte to TX data register, pulse req_ready
// GUARD | wait GUARD_CYCLES for TX-ready to drop before polling again
module uart_tx_arbiter #(
    parameter int N_REQ        = 2,
    parameter int GUARD_CYCLES = 2,
    parameter int LOCK_TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          rst,
    uart_tx_arbiter_if.master bus
);
    localparam int SW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam int IW = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;

    localparam logic [1:0] ADDR_STATUS = 2'b01;
    localparam logic [1:0] ADDR_TXDATA = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        POLL  = 2'd1,
        WRITE = 2'd2,
        GUARD = 2'd3
    } state_t;

    state_t         state, state_nxt;
    logic [SW-1:0]  sel, sel_nxt;
    logic [SW-1:0]  last_grant, last_grant_nxt;
    logic [SW-1:0]  owner, owner_nxt;
    logic           locked, locked_nxt;
    logic [GW-1:0]  guard_cnt, guard_cnt_nxt;
    logic [IW-1:0]  idle_cnt, idle_cnt_nxt;
    logic [7:0]     data_q, data_q_nxt;

    logic           cand_found;
    logic [SW-1:0]  cand;
    logic [SW:0]    scan_sum;
    logic [SW-1:0]  scan_idx;
    logic [N_REQ-1:0] sel_onehot;

    // Only bit1 of the status register matters; the rest is deliberately dropped.
    logic unused_rd_bits;
    assign unused_rd_bits = ^{bus.mmio_rd_data[7:2], bus.mmio_rd_data[0]};

    assign sel_onehot = N_REQ'(1) << sel;

    // Round-robin scan starting one past the last grant; a held lock narrows it to the owner.
    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        if (locked) begin
            cand       = owner;
            cand_found = bus.req_valid[owner];
        end else begin
            for (int i = 1; i <= N_REQ; i++) begin
                scan_sum = {1'b0, last_grant} + (SW+1)'(i);
                if (scan_sum >= (SW+1)'(N_REQ))
                    scan_sum = scan_sum - (SW+1)'(N_REQ);
                scan_idx = scan_sum[SW-1:0];
                if (!cand_found && bus.req_valid[scan_idx]) begin
                    cand_found = 1'b1;
                    cand       = scan_idx;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            sel        <= '0;
            last_grant <= SW'(N_REQ-1);
            owner      <= '0;
            locked     <= 1'b0;
            guard_cnt  <= '0;
            idle_cnt   <= '0;
            data_q     <= '0;
        end else begin
            state      <= state_nxt;
            sel        <= sel_nxt;
            last_grant <= last_grant_nxt;
            owner      <= owner_nxt;
            locked     <= locked_nxt;
            guard_cnt  <= guard_cnt_nxt;
            idle_cnt   <= idle_cnt_nxt;
            data_q     <= data_q_nxt;
        end
    end

    // Outputs decode from registered state only; the byte is held in data_q from arbitration on.
    always_comb begin
        state_nxt      = state;
        sel_nxt        = sel;
        last_grant_nxt = last_grant;
        owner_nxt      = owner;
        locked_nxt     = locked;
        guard_cnt_nxt  = guard_cnt;
        idle_cnt_nxt   = idle_cnt;
        data_q_nxt     = data_q;

        bus.mmio_addr    = ADDR_STATUS;
        bus.mmio_wr_en   = 1'b0;
        bus.mmio_wr_data = 8'h00;
        bus.req_ready    = '0;
        bus.grant        = '0;
        bus.busy         = (state != IDLE) || locked;

        case (state)
            IDLE: begin
                if (cand_found) begin
                    sel_nxt      = cand;
                    data_q_nxt   = bus.req_data[{cand, 3'b000} +: 8];
                    idle_cnt_nxt = '0;
                    state_nxt    = POLL;
                end else if (locked && !bus.req_valid[owner] && (LOCK_TIMEOUT != 0)) begin
                    if (idle_cnt == IW'(LOCK_TIMEOUT-1)) begin
                        locked_nxt   = 1'b0;
                        idle_cnt_nxt = '0;
                    end else begin
                        idle_cnt_nxt = idle_cnt + 1'b1;
                    end
                end
            end
            POLL: begin
                bus.grant = sel_onehot;
                if (bus.mmio_rd_data[1])
                    state_nxt = WRITE;
            end
            WRITE: begin
                bus.mmio_addr    = ADDR_TXDATA;
                bus.mmio_wr_en   = 1'b1;
                bus.mmio_wr_data = data_q;
                bus.req_ready    = sel_onehot;
                bus.grant        = sel_onehot;
                last_grant_nxt   = sel;
                owner_nxt        = sel;
                locked_nxt       = ~bus.req_last[sel];
                guard_cnt_nxt    = '0;
                state_nxt        = GUARD;
            end
            GUARD: begin
                bus.grant     = sel_onehot;
                guard_cnt_nxt = guard_cnt + 1'b1;
                if (guard_cnt == GW'(GUARD_CYCLES-1))
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: table of single-byte transfers plus
// hand-written sequences for lock timeout, packet lock, fairness and reset.
module tb_uart_tx_arbiter;
    localparam int N_REQ   = 2;
    localparam int GUARD   = 2;
    localparam int LOCK_TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.N_REQ(N_REQ)) bus ();

    uart_tx_arbiter #(
        .N_REQ(N_REQ),
        .GUARD_CYCLES(GUARD),
        .LOCK_TIMEOUT(LOCK_TO)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic       v [N_REQ];
    logic [7:0] d [N_REQ];
    logic       l [N_REQ];
    logic       tx_rdy;

    always_comb begin
        bus.req_valid = '0;
        bus.req_data  = '0;
        bus.req_last  = '0;
        for (int i = 0; i < N_REQ; i++) begin
            bus.req_valid[i]       = v[i];
            bus.req_data[8*i +: 8] = d[i];
            bus.req_last[i]        = l[i];
        end
    end

    // UART status model: bit1 = TX ready, bit0 held high to show it is ignored.
    always_comb begin
        bus.mmio_rd_data = 8'h00;
        if (bus.mmio_addr == 2'b01)
            bus.mmio_rd_data = {6'b0, tx_rdy, 1'b1};
    end

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         req;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   wr_cyc_q[$];

    // Monitor: protocol invariants every cycle, scoreboard pop on every TX write.
    always @(negedge clk) begin
        logic inv_ok;
        exp_t e;
        inv_ok = (bus.mmio_addr != 2'b11) && (bus.mmio_addr != 2'b00)
               && (bus.mmio_wr_en == (bus.req_ready != '0))
               && $onehot0(bus.req_ready)
               && (!bus.mmio_wr_en || bus.mmio_addr == 2'b10);
        check("protocol_invariant", 32'(inv_ok), 32'd1);
        if (bus.mmio_wr_en) begin
            wr_cyc_q.push_back(cyc);
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: got data 0x%0h, expected no write (cycle %0d)",
                         bus.mmio_wr_data, cyc);
            end else begin
                e = sb_q.pop_front();
                check("write_data", 32'(bus.mmio_wr_data), 32'(e.data));
                check("write_ready", 32'(bus.req_ready), 32'(1) << e.req);
                check("write_grant", 32'(bus.grant), 32'(1) << e.req);
            end
        end
    end

    // Called at posedge+1; holds the byte until req_ready, then drops valid after the accepting edge.
    task automatic send(int r, logic [7:0] data, logic last);
        int k;
        v[r] = 1'b1;
        d[r] = data;
        l[r] = last;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.req_ready[r] && k < 400);
        if (!bus.req_ready[r]) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: requester %0d got no req_ready, expected one within 400 cycles", r);
        end
        @(posedge clk);
        #1;
        v[r] = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        check({tag, "_addr"},  32'(bus.mmio_addr), 32'd1);
        check({tag, "_wr_en"}, 32'(bus.mmio_wr_en), 32'd0);
        check({tag, "_wdata"}, 32'(bus.mmio_wr_data), 32'd0);
        check({tag, "_ready"}, 32'(bus.req_ready), 32'd0);
        check({tag, "_grant"}, 32'(bus.grant), 32'd0);
        check({tag, "_busy"},  32'(bus.busy), 32'd0);
    endtask

    function automatic int last_wr();
        return (wr_cyc_q.size() > 0) ? wr_cyc_q[$] : -1000;
    endfunction

    task automatic idle_wait(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    typedef struct {
        int         req;
        logic [7:0] data;
        int         stall;
        int         lat;
    } vec_t;

    vec_t tbl[5];

    initial begin
        int t0, w0, k, n;
        tbl[0] = '{0, 8'h41, 0, 2};
        tbl[1] = '{1, 8'h7E, 0, 2};
        tbl[2] = '{0, 8'h00, 1, 2};
        tbl[3] = '{1, 8'hFF, 3, 4};
        tbl[4] = '{0, 8'h55, 50, 51};

        for (int i = 0; i < N_REQ; i++) begin
            v[i] = 1'b0;
            d[i] = 8'h00;
            l[i] = 1'b1;
        end
        tx_rdy = 1'b1;

        idle_wait(2);
        check_reset_outputs("reset");
        rst = 1'b0;
        idle_wait(2);

        foreach (tbl[i]) begin
            sb_q.push_back('{tbl[i].req, tbl[i].data});
            tx_rdy = (tbl[i].stall == 0);
            t0 = cyc;
            fork
                send(tbl[i].req, tbl[i].data, 1'b1);
                begin
                    if (tbl[i].stall > 0) begin
                        repeat (tbl[i].stall) @(posedge clk);
                        #1;
                        if (tbl[i].stall >= 2) begin
                            check("poll_grant", 32'(bus.grant), 32'(1) << tbl[i].req);
                            check("poll_busy", 32'(bus.busy), 32'd1);
                        end
                        tx_rdy = 1'b1;
                    end
                end
            join
            check("latency", 32'(last_wr() - t0), 32'(tbl[i].lat));
            idle_wait(2);
            check("idle_busy", 32'(bus.busy), 32'd0);
            check("idle_grant", 32'(bus.grant), 32'd0);
            idle_wait(1);
        end

        // Lock timeout: owner 0 stalls mid-packet, requester 1 must wait out LOCK_TO idle cycles.
        sb_q.push_back('{0, 8'h11});
        sb_q.push_back('{1, 8'h22});
        send(0, 8'h11, 1'b0);
        w0 = last_wr();
        fork
            send(1, 8'h22, 1'b1);
            begin
                idle_wait(8);
                check("lock_hold_grant", 32'(bus.grant), 32'd0);
                check("lock_hold_busy", 32'(bus.busy), 32'd1);
            end
        join
        check("lock_timeout_gap", 32'(last_wr() - w0), 32'(GUARD + LOCK_TO + 3));
        idle_wait(4);

        // Packet lock: 48,49 from requester 0 must not be split by requester 1's 5A.
        sb_q.push_back('{0, 8'h48});
        sb_q.push_back('{0, 8'h49});
        sb_q.push_back('{1, 8'h5A});
        n = wr_cyc_q.size();
        fork
            begin
                send(0, 8'h48, 1'b0);
                send(0, 8'h49, 1'b1);
            end
            send(1, 8'h5A, 1'b1);
        join
        check("lock_writes", 32'(wr_cyc_q.size() - n), 32'd3);
        if (wr_cyc_q.size() - n == 3) begin
            check("lock_gap0", 32'(wr_cyc_q[n+1] - wr_cyc_q[n]), 32'(3 + GUARD));
            check("lock_gap1", 32'(wr_cyc_q[n+2] - wr_cyc_q[n+1]), 32'(3 + GUARD));
        end
        idle_wait(4);

        // Fairness: both continuously valid, writes alternate at minimum spacing.
        for (int k2 = 0; k2 < 4; k2++) begin
            sb_q.push_back('{0, 8'hA0 + 8'(k2)});
            sb_q.push_back('{1, 8'hB0 + 8'(k2)});
        end
        n = wr_cyc_q.size();
        fork
            for (int k2 = 0; k2 < 4; k2++) send(0, 8'hA0 + 8'(k2), 1'b1);
            for (int k3 = 0; k3 < 4; k3++) send(1, 8'hB0 + 8'(k3), 1'b1);
        join
        check("fair_writes", 32'(wr_cyc_q.size() - n), 32'd8);
        if (wr_cyc_q.size() - n == 8)
            for (int j = 1; j < 8; j++)
                check("fair_gap", 32'(wr_cyc_q[n+j] - wr_cyc_q[n+j-1]), 32'(3 + GUARD));
        idle_wait(4);

        // Reset during GUARD.
        sb_q.push_back('{0, 8'h33});
        send(0, 8'h33, 1'b1);
        check("guard_grant_pre", 32'(bus.grant), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_guard");
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle_wait(2);

        // Reset during WRITE, requester 1 mid-packet.
        sb_q.push_back('{1, 8'h66});
        v[1] = 1'b1;
        d[1] = 8'h66;
        l[1] = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!bus.mmio_wr_en && k < 20);
        check("rst_write_reached", 32'(bus.mmio_wr_en), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_write");
        v[1] = 1'b0;
        l[1] = 1'b1;
        @(posedge clk);
        #1;
        check("rst_write_no_ready", 32'(bus.req_ready), 32'd0);
        rst = 1'b0;
        idle_wait(2);

        // After reset requester 0 wins first.
        sb_q.push_back('{0, 8'h70});
        sb_q.push_back('{1, 8'h71});
        fork
            send(0, 8'h70, 1'b1);
            send(1, 8'h71, 1'b1);
        join
        idle_wait(4);

        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000 time units, expected finish");
        $fatal(1, "watchdog expired");
    end
endmodule
